// File: rtl/fifth_loader.sv
// Byte-stream boot loader into code RAM; holds the core in reset until the image is done (FIFTH_LOADER_CHECKSUM_EN adds an XOR trailer byte).
// Each word is written 1 cycle after its low byte; rx_ready drops for that write cycle and while in RUN.
module fifth_loader #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic              reload,
  output logic              code_we,
  output logic [ADDR_W-1:0] code_waddr,
  output logic [15:0]       code_wdata,
  output logic              cpu_run,
  output logic              load_error,
  output logic              busy
);

  typedef enum logic [2:0] {
    HDR_HI,
    HDR_LO,
    DATA_HI,
    DATA_LO,
    WR_WORD,
`ifdef FIFTH_LOADER_CHECKSUM_EN
    CSUM,
`endif
    RUN,
    ERROR
  } state_t;

  localparam logic [16:0] CAPACITY = 17'd1 << ADDR_W;

  state_t            state;
  logic [7:0]        len_hi;
  logic [7:0]        data_hi;
  logic [15:0]       words_left;
  logic [ADDR_W-1:0] addr;
  logic [16:0]       len;
  logic              accept;

  // A byte offered alongside reload is dropped, not consumed.
  assign accept   = rx_valid && rx_ready && !reload;
  assign rx_ready = (state != RUN) && (state != WR_WORD);
  assign len      = {1'b0, len_hi, rx_data};

`ifdef FIFTH_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      csum <= 8'h00;
    end else if (state == HDR_HI) begin
      csum <= 8'h00;
    end else if (accept && (state == DATA_HI || state == DATA_LO)) begin
      csum <= csum ^ rx_data;
    end
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= HDR_HI;
      len_hi     <= 8'h00;
      data_hi    <= 8'h00;
      words_left <= 16'h0000;
      addr       <= '0;
      code_we    <= 1'b0;
      code_waddr <= '0;
      code_wdata <= 16'h0000;
      cpu_run    <= 1'b0;
      load_error <= 1'b0;
      busy       <= 1'b1;
    end else if (reload) begin
      state      <= HDR_HI;
      code_we    <= 1'b0;
      cpu_run    <= 1'b0;
      load_error <= 1'b0;
      busy       <= 1'b1;
    end else begin
      code_we <= 1'b0;
      case (state)
        HDR_HI: begin
          if (accept) begin
            len_hi <= rx_data;
            state  <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept) begin
            if (len > CAPACITY) begin
              state      <= ERROR;
              load_error <= 1'b1;
              busy       <= 1'b0;
            end else if (len == 17'd0) begin
`ifdef FIFTH_LOADER_CHECKSUM_EN
              state   <= CSUM;
`else
              state   <= RUN;
              cpu_run <= 1'b1;
              busy    <= 1'b0;
`endif
            end else begin
              state      <= DATA_HI;
              words_left <= len[15:0];
              addr       <= '0;
            end
          end
        end
        DATA_HI: begin
          if (accept) begin
            data_hi <= rx_data;
            state   <= DATA_LO;
          end
        end
        DATA_LO: begin
          if (accept) begin
            code_we    <= 1'b1;
            code_waddr <= addr;
            code_wdata <= {data_hi, rx_data};
            addr       <= addr + 1'b1;
            words_left <= words_left - 1'b1;
            state      <= WR_WORD;
          end
        end
        WR_WORD: begin
          // words_left was already decremented for the word being written now.
          if (words_left == 16'h0000) begin
`ifdef FIFTH_LOADER_CHECKSUM_EN
            state   <= CSUM;
`else
            state   <= RUN;
            cpu_run <= 1'b1;
            busy    <= 1'b0;
`endif
          end else begin
            state <= DATA_HI;
          end
        end
`ifdef FIFTH_LOADER_CHECKSUM_EN
        CSUM: begin
          if (accept) begin
            busy <= 1'b0;
            if (rx_data == csum) begin
              state   <= RUN;
              cpu_run <= 1'b1;
            end else begin
              state      <= ERROR;
              load_error <= 1'b1;
            end
          end
        end
`endif
        RUN:     ;
        ERROR:   ;
        default: state <= HDR_HI;
      endcase
    end
  end

endmodule
